spi_slave_ctrl: RTL and testbench
=================================

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have parameter TX_TIMEOUT, default 15, meaning the number of cycles WAIT_TX waits for tx_valid before aborting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ss_n, input, 1 bit: active-low slave select.
REQ-005 SHALL have port stp_enable, output, 1 bit: enable to the serial-to-parallel converter.
REQ-006 SHALL have port stp_data, input, 10 bits: converter parallel word; [9:8] is the command, [7:0] the payload.
REQ-007 SHALL have port stp_done, input, 1 bit: one-cycle pulse when the converter holds a complete 10-bit word.
REQ-008 SHALL have port rx_data, output, 10 bits: word forwarded to the RAM.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-cycle qualifier for rx_data.
REQ-010 SHALL have port tx_data, input, 8 bits: RAM read data.
REQ-011 SHALL have port tx_valid, input, 1 bit: qualifier for tx_data.
REQ-012 SHALL have port miso, output, 1 bit: serial read data, MSB first.
REQ-013 SHALL have port tx_busy, output, 1 bit: high while in SEND.
REQ-014 SHALL have port cmd_err, output, 1 bit: one-cycle error pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, RECV, DISPATCH, WAIT_TX and SEND, with all outputs registered or decoded from state only.
REQ-016 IDLE: stp_enable=0 and miso=0; ss_n=0 -> RECV next cycle.
REQ-017 RECV: stp_enable=1; on stp_done, SHALL latch stp_data and go to DISPATCH.
REQ-018 DISPATCH SHALL last exactly one cycle, with rx_data equal to the latched word and rx_valid=1, so rx_valid is high in the cycle after stp_done.
REQ-019 Command 10 (read address) SHALL set rd_addr_flag; commands 00 and 01 SHALL leave it unchanged; all three SHALL go to RECV.
REQ-020 Command 11 with rd_addr_flag=1 SHALL clear the flag and go to WAIT_TX.
REQ-021 Command 11 with rd_addr_flag=0 SHALL suppress rx_valid, pulse cmd_err and go to RECV.
REQ-022 WAIT_TX: stp_enable=0; tx_valid=1 SHALL load tx_data into the shifter and go to SEND.
REQ-023 WAIT_TX SHALL time out when TX_TIMEOUT cycles elapse without tx_valid: pulse cmd_err and go to IDLE.
REQ-024 SEND SHALL drive miso with bits 7 down to 0 on 8 consecutive cycles, starting the cycle after tx_valid, then go to RECV.
REQ-025 tx_valid outside WAIT_TX SHALL be ignored.
REQ-026 In any state other than IDLE, ss_n=1 SHALL force IDLE on the next edge, with these effects:
- an aborted word produces no rx_valid;
- miso returns to 0 and the shifter clears;
- rd_addr_flag is retained.
REQ-027 When stp_done and ss_n=1 arrive in the same cycle, ss_n SHALL win and no rx_valid is produced.
REQ-028 The bit counter SHALL be 3 bits wide, and the timeout counter SHALL be $clog2(TX_TIMEOUT+1) bits wide, saturating and cleared on every entry to WAIT_TX.

Reset
REQ-029 On rst=1, the block SHALL immediately enter IDLE with these values:
- outputs: stp_enable=0, rx_data=0, rx_valid=0, miso=0, tx_busy=0, cmd_err=0;
- internal state: rd_addr_flag=0, counters=0, shifter=0.
REQ-030 Reset asserted mid-SEND or mid-RECV SHALL abort with no further rx_valid or miso activity, and operation SHALL resume with ss_n low after rst deasserts.

Structure
REQ-031 A shared package spi_pkg SHALL hold:
- the state enumeration;
- the command codes CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11;
- the word width constant 10.
REQ-032 The 8-bit load/shift register with its bit counter SHALL be one sub-module, spi_tx_shifter; the FSM stays in spi_slave_ctrl.

Verification
REQ-033 Write address: ss_n=0, stp_data=10'h0A5 with stp_done -> rx_data=10'h0A5 and rx_valid for exactly 1 cycle, the cycle after stp_done; state returns to RECV.
REQ-034 Read sequence: stp_data=10'h212, then 10'h300, then tx_valid with tx_data=8'hC3 -> miso = 1,1,0,0,0,0,1,1 over the 8 cycles after tx_valid, tx_busy high for those 8 cycles, then RECV.
REQ-035 Read data without a prior read address: stp_data=10'h3FF after reset -> no rx_valid, cmd_err pulses once, state stays in RECV.
REQ-036 Timeout: read address then read data, with tx_valid held low for 15 cycles -> cmd_err pulses once, state goes to IDLE, miso stays 0.
REQ-037 Abort: ss_n rises on the 4th SEND bit of tx_data=8'hFF -> miso=0 and IDLE on the next cycle, with no further bits shifted out.
REQ-038 Reset mid-RECV with stp_done pulsing in the same cycle -> no rx_valid, and all outputs zero while rst=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave controller.
// Holds the controller state enumeration, the 2-bit command codes carried in
// the top bits of every received word, and the word/data widths.
package spi_pkg;

  localparam int WORD_W = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DISPATCH,
    ST_WAIT_TX,
    ST_SEND
  } state_t;

  // Command field of a received word.
  function automatic logic [1:0] cmd_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-data shifter: an 8-bit load/shift register, MSB out first, with a
// 3-bit bit counter flagging the last bit of a byte.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - zero register and counter (abort / idle)
//   load       - capture load_data, restart bit count
//   shift      - move to the next bit
//   load_data  - byte to serialise
//   ser_out    - current bit (register MSB)
//   last_bit   - the bit on ser_out is the eighth of the byte
module spi_tx_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              ser_out,
  output logic              last_bit
);

  logic [DATA_W-1:0] shreg_q;
  logic [2:0]        bit_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (clear) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      shreg_q   <= load_data;
      bit_cnt_q <= '0;
    end else if (shift) begin
      // Zero fill, so the register is empty once a full byte has gone out.
      shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  assign ser_out  = shreg_q[DATA_W-1];
  assign last_bit = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol controller. Receives 10-bit words from an external
// serial-to-parallel converter, forwards them to a RAM, and serialises RAM
// read data back out on miso after a read-address / read-data pair.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   ss_n             - active-low slave select; deassertion aborts to IDLE
//   stp_enable       - enable to the serial-to-parallel converter
//   stp_data/done    - converter word ([9:8] command, [7:0] payload) + strobe
//   rx_data/valid    - word forwarded to the RAM, one-cycle qualifier
//   tx_data/valid    - RAM read data and qualifier (used only in WAIT_TX)
//   miso             - serial read data, MSB first
//   tx_busy          - high while shifting read data out
//   cmd_err          - one-cycle pulse: read data without address, or timeout
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | deselected, converter off, shifter held clear
// ST_RECV     | converter enabled, waiting for a complete word
// ST_DISPATCH | one cycle: present word to RAM, decode command
// ST_WAIT_TX  | waiting for RAM read data, bounded by TX_TIMEOUT cycles
// ST_SEND     | shifting 8 read-data bits out on miso
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  output logic              stp_enable,
  input  logic [WORD_W-1:0] stp_data,
  input  logic              stp_done,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              miso,
  output logic              tx_busy,
  output logic              cmd_err
);

  localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TX_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q;
  logic              rd_addr_flag_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              cmd_err_q;
  logic [1:0]        cmd;

  logic latch_word, flag_set, flag_clr, err_set;
  logic sh_clear, sh_load, sh_shift, sh_out, sh_last;

  assign cmd = cmd_of(word_q);

  spi_tx_shifter u_tx_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (sh_clear),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (tx_data),
    .ser_out   (sh_out),
    .last_bit  (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      rd_addr_flag_q <= 1'b0;
      tmo_cnt_q      <= '0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= err_set;
      if (latch_word) word_q <= stp_data;
      if (flag_set)      rd_addr_flag_q <= 1'b1;
      else if (flag_clr) rd_addr_flag_q <= 1'b0;
      // Held at zero outside WAIT_TX, so every entry starts a fresh count.
      if (state_q != ST_WAIT_TX)  tmo_cnt_q <= '0;
      else if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    latch_word = 1'b0;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    err_set    = 1'b0;
    sh_clear   = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    stp_enable = 1'b0;
    rx_valid   = 1'b0;
    tx_busy    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sh_clear = 1'b1;
        if (!ss_n) state_d = ST_RECV;
      end

      ST_RECV: begin
        stp_enable = 1'b1;
        // Deselect takes priority over a word completing in the same cycle.
        if (ss_n) begin
          state_d = ST_IDLE;
        end else if (stp_done) begin
          latch_word = 1'b1;
          state_d    = ST_DISPATCH;
        end
      end

      ST_DISPATCH: begin
        // A read-data word with no preceding read address is dropped.
        rx_valid = !((cmd == CMD_RD_DATA) && !rd_addr_flag_q);
        if (ss_n) begin
          state_d = ST_IDLE;
        end else begin
          case (cmd)
            CMD_RD_ADDR: begin
              flag_set = 1'b1;
              state_d  = ST_RECV;
            end
            CMD_RD_DATA: begin
              if (rd_addr_flag_q) begin
                flag_clr = 1'b1;
                state_d  = ST_WAIT_TX;
              end else begin
                err_set = 1'b1;
                state_d = ST_RECV;
              end
            end
            default: state_d = ST_RECV;
          endcase
        end
      end

      ST_WAIT_TX: begin
        if (ss_n) begin
          state_d = ST_IDLE;
        end else if (tx_valid) begin
          sh_load = 1'b1;
          state_d = ST_SEND;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        tx_busy = 1'b1;
        if (ss_n) begin
          sh_clear = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          sh_shift = 1'b1;
          if (sh_last) state_d = ST_RECV;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data = word_q;
  assign cmd_err = cmd_err_q;
  assign miso    = (state_q == ST_SEND) && sh_out;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;

  localparam int TX_TIMEOUT = 15;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ss_n     = 1'b1;
  logic [9:0] stp_data = '0;
  logic       stp_done = 1'b0;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       stp_enable, rx_valid, miso, tx_busy, cmd_err;
  logic [9:0] rx_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss_n       (ss_n),
    .stp_enable (stp_enable),
    .stp_data   (stp_data),
    .stp_done   (stp_done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .miso       (miso),
    .tx_busy    (tx_busy),
    .cmd_err    (cmd_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks what the link is doing (listening, one word
  // pending for the RAM, waiting for read data, a queue of bits to send).
  bit         m_listen, m_disp, m_wait, m_flag, m_err;
  logic [9:0] m_word;
  int         m_wcnt;
  bit         m_bits[$];

  task automatic model_update();
    bit idle;
    if (rst) begin
      m_listen = 0; m_disp = 0; m_wait = 0; m_flag = 0; m_err = 0;
      m_word = '0; m_wcnt = 0; m_bits.delete();
      return;
    end
    idle  = !m_listen && !m_disp && !m_wait && (m_bits.size() == 0);
    m_err = 0;
    if (idle) begin
      m_listen = !ss_n;
    end else if (ss_n) begin
      m_listen = 0; m_disp = 0; m_wait = 0; m_bits.delete();
    end else if (m_listen) begin
      if (stp_done) begin
        m_word = stp_data; m_listen = 0; m_disp = 1;
      end
    end else if (m_disp) begin
      m_disp = 0;
      case (m_word[9:8])
        2'b11: if (m_flag) begin m_flag = 0; m_wait = 1; m_wcnt = 0; end
               else begin m_err = 1; m_listen = 1; end
        2'b10: begin m_flag = 1; m_listen = 1; end
        default: m_listen = 1;
      endcase
    end else if (m_wait) begin
      if (tx_valid) begin
        m_wait = 0;
        for (int b = 7; b >= 0; b--) m_bits.push_back(tx_data[b]);
      end else begin
        m_wcnt++;
        if (m_wcnt == TX_TIMEOUT) begin m_wait = 0; m_err = 1; end
      end
    end else begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) m_listen = 1;
    end
  endtask

  task automatic compare_all();
    bit   e_en, e_rv, e_miso, e_busy, e_err;
    logic [9:0] e_rd;
    if (rst) begin
      e_en = 0; e_rv = 0; e_miso = 0; e_busy = 0; e_err = 0; e_rd = '0;
    end else begin
      e_en   = m_listen;
      e_rv   = m_disp && !((m_word[9:8] == 2'b11) && !m_flag);
      e_rd   = m_word;
      e_miso = (m_bits.size() > 0) ? m_bits[0] : 1'b0;
      e_busy = (m_bits.size() > 0);
      e_err  = m_err;
    end
    chk("cyc_stp_enable", 32'(stp_enable), 32'(e_en));
    chk("cyc_rx_valid",   32'(rx_valid),   32'(e_rv));
    chk("cyc_miso",       32'(miso),       32'(e_miso));
    chk("cyc_tx_busy",    32'(tx_busy),    32'(e_busy));
    chk("cyc_cmd_err",    32'(cmd_err),    32'(e_err));
    if (e_rv) chk("cyc_rx_data", 32'(rx_data), 32'(e_rd));
  endtask

  initial forever begin @(posedge clk); model_update(); end
  initial forever begin @(negedge clk); #1; compare_all(); end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic send_word(input logic [9:0] w);
    stp_data = w; stp_done = 1'b1; step();
    stp_done = 1'b0; step();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stp_enable"}, 32'(stp_enable), 0);
    chk({tag, "_rx_data"},    32'(rx_data),    0);
    chk({tag, "_rx_valid"},   32'(rx_valid),   0);
    chk({tag, "_miso"},       32'(miso),       0);
    chk({tag, "_tx_busy"},    32'(tx_busy),    0);
    chk({tag, "_cmd_err"},    32'(cmd_err),    0);
  endtask

  bit exp_c3[8] = '{1, 1, 0, 0, 0, 0, 1, 1};

  initial begin
    // Reset state
    step(); step();
    all_zero("rst");
    rst = 1'b0; step();
    chk("idle_enable", 32'(stp_enable), 0);

    // Write address
    ss_n = 1'b0; step();
    chk("recv_enable", 32'(stp_enable), 1);
    stp_data = 10'h0A5; stp_done = 1'b1; step();
    stp_done = 1'b0;
    chk("wa_rx_valid", 32'(rx_valid), 1);
    chk("wa_rx_data",  32'(rx_data), 32'h0A5);
    step();
    chk("wa_rx_valid_one", 32'(rx_valid), 0);
    chk("wa_back_recv", 32'(stp_enable), 1);

    // tx_valid outside WAIT_TX is ignored
    tx_data = 8'hAA; tx_valid = 1'b1; step();
    tx_valid = 1'b0; step();
    chk("stray_tx_miso", 32'(miso), 0);
    chk("stray_tx_busy", 32'(tx_busy), 0);

    // Read sequence
    send_word(10'h212);
    stp_data = 10'h300; stp_done = 1'b1; step();
    stp_done = 1'b0;
    chk("rd_rx_valid", 32'(rx_valid), 1);
    step();
    chk("wait_enable", 32'(stp_enable), 0);
    tx_data = 8'hC3; tx_valid = 1'b1; step();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd_miso_%0d", i), 32'(miso), 32'(exp_c3[i]));
      chk("rd_busy", 32'(tx_busy), 1);
      step();
    end
    chk("rd_busy_end", 32'(tx_busy), 0);
    chk("rd_back_recv", 32'(stp_enable), 1);

    // Read data without read address
    rst = 1'b1; step();
    rst = 1'b0; step();
    stp_data = 10'h3FF; stp_done = 1'b1; step();
    stp_done = 1'b0;
    chk("noaddr_rx_valid", 32'(rx_valid), 0);
    step();
    chk("noaddr_err", 32'(cmd_err), 1);
    chk("noaddr_recv", 32'(stp_enable), 1);
    step();
    chk("noaddr_err_once", 32'(cmd_err), 0);

    // Timeout
    send_word(10'h212);
    send_word(10'h300);
    repeat (14) step();
    chk("tmo_early", 32'(cmd_err), 0);
    step();
    chk("tmo_err", 32'(cmd_err), 1);
    chk("tmo_idle", 32'(stp_enable), 0);
    chk("tmo_miso", 32'(miso), 0);
    step();
    chk("tmo_err_once", 32'(cmd_err), 0);
    chk("tmo_resume", 32'(stp_enable), 1);

    // Abort on the 4th SEND bit
    send_word(10'h212);
    send_word(10'h300);
    tx_data = 8'hFF; tx_valid = 1'b1; step();
    tx_valid = 1'b0;
    repeat (3) step();
    chk("abort_bit4", 32'(miso), 1);
    ss_n = 1'b1; step();
    chk("abort_miso", 32'(miso), 0);
    chk("abort_busy", 32'(tx_busy), 0);
    chk("abort_idle", 32'(stp_enable), 0);
    step();
    chk("abort_miso2", 32'(miso), 0);

    // Read-address flag survives an abort
    ss_n = 1'b0; step();
    send_word(10'h212);
    ss_n = 1'b1; step();
    ss_n = 1'b0; step();
    stp_data = 10'h300; stp_done = 1'b1; step();
    stp_done = 1'b0;
    chk("flag_kept_rx_valid", 32'(rx_valid), 1);
    step();
    chk("flag_kept_no_err", 32'(cmd_err), 0);
    tx_data = 8'h5A; tx_valid = 1'b1; step();
    tx_valid = 1'b0;
    repeat (8) step();

    // stp_done and deselect together
    stp_data = 10'h0A5; stp_done = 1'b1; ss_n = 1'b1; step();
    stp_done = 1'b0;
    chk("sel_win_rx_valid", 32'(rx_valid), 0);
    chk("sel_win_idle", 32'(stp_enable), 0);
    step();
    chk("sel_win_rx_valid2", 32'(rx_valid), 0);

    // Reset mid-RECV with stp_done
    ss_n = 1'b0; step();
    stp_data = 10'h155; stp_done = 1'b1; rst = 1'b1; #1;
    all_zero("rst_recv");
    step();
    stp_done = 1'b0;
    chk("rst_recv_rx_valid", 32'(rx_valid), 0);
    rst = 1'b0; step();
    chk("rst_recv_resume", 32'(stp_enable), 1);
    chk("rst_recv_rx_valid2", 32'(rx_valid), 0);

    // Reset mid-SEND
    send_word(10'h212);
    send_word(10'h300);
    tx_data = 8'hC3; tx_valid = 1'b1; step();
    tx_valid = 1'b0; step();
    rst = 1'b1; #1;
    chk("rst_send_miso", 32'(miso), 0);
    chk("rst_send_busy", 32'(tx_busy), 0);
    step();
    rst = 1'b0; step();
    chk("rst_send_miso2", 32'(miso), 0);
    chk("rst_send_resume", 32'(stp_enable), 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
